// File: rtl/seq_range_checker.sv
// Per-channel start->done distance checker; verdicts are registered one cycle after the deciding edge.
// Pure monitor, no backpressure. Define SEQ_RANGE_CHECKER_STATS_EN to build pass_cnt/fail_cnt.
module seq_range_checker #(
  parameter int NCH        = 4,
  parameter int MIN_DLY    = 1,
  parameter int MAX_DLY    = 4,
  parameter int EARLY_FAIL = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] done,
  input  logic [NCH-1:0] dis,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] pass,
  output logic [NCH-1:0] fail,
  output logic [NCH-1:0] ovl,
  output logic [15:0]    fail_cnt,
  output logic [15:0]    pass_cnt
);
  localparam int CW = $clog2(MAX_DLY + 2);

  typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] pass_q, pass_d;
  logic [NCH-1:0] fail_q, fail_d;
  logic [NCH-1:0] ovl_q, ovl_d;

  always_comb begin
    pass_d = '0;
    fail_d = '0;
    ovl_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (start[i] && !dis[i]) begin
            state_d[i] = WAIT;
            cnt_d[i]   = '0;
          end
        end
        WAIT: begin
          if (dis[i]) begin
            state_d[i] = IDLE;
          end else begin
            // The distance of this edge from the start edge is cnt_q + 1.
            if (int'(cnt_q[i]) == MAX_DLY) begin
              fail_d[i] = 1'b1;
            end else if (done[i] && (int'(cnt_q[i]) + 1 >= MIN_DLY)) begin
              pass_d[i] = 1'b1;
            end else if (done[i] && (EARLY_FAIL != 0)) begin
              fail_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
              ovl_d[i] = start[i];
            end
            // A verdict frees the channel on this same edge, so a coincident start reopens it.
            if (pass_d[i] || fail_d[i]) begin
              state_d[i] = start[i] ? WAIT : IDLE;
              cnt_d[i]   = '0;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pass_q <= '0;
      fail_q <= '0;
      ovl_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pass_q <= pass_d;
      fail_q <= fail_d;
      ovl_q  <= ovl_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (state_q[i] == WAIT);
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
  assign ovl  = ovl_q;

`ifdef SEQ_RANGE_CHECKER_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;

  function automatic logic [6:0] popcnt(input logic [NCH-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int j = 0; j < NCH; j++) begin
      c = c + {6'b0, v[j]};
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [6:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {10'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Counters track the pulses being registered this edge, so they move together with pass/fail.
  always_comb begin
    pass_cnt_d = sat_add(pass_cnt_q, popcnt(pass_d));
    fail_cnt_d = sat_add(fail_cnt_q, popcnt(fail_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`else
  assign pass_cnt = 16'h0000;
  assign fail_cnt = 16'h0000;
`endif

endmodule

// File: doc/seq_range_checker.md
SEQ_RANGE_CHECKER -- requirements
Module: seq_range_checker

Interface
REQ-001 Parameter NCH, default 4, number of independent channels (1..32) SHALL be supported.
REQ-002 Parameter MIN_DLY, default 1, SHALL set the earliest accepted start-to-done distance in cycles (>=1).
REQ-003 Parameter MAX_DLY, default 4, SHALL set the latest accepted start-to-done distance in cycles (MIN_DLY..255).
REQ-004 Parameter EARLY_FAIL, default 1, SHALL make done before MIN_DLY a failure (1) or ignored (0).
REQ-005 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 start  input  NCH  SHALL open an attempt per channel when sampled high.
REQ-008 done  input  NCH  SHALL be the per-channel completion event.
REQ-009 dis  input  NCH  SHALL abort the channel's attempt (disable-iff), with no verdict.
REQ-010 busy  output  NCH  SHALL be high while the channel has an open attempt.
REQ-011 pass  output  NCH  SHALL pulse one cycle on an in-window done.
REQ-012 fail  output  NCH  SHALL pulse one cycle on early done or timeout.
REQ-013 ovl  output  NCH  SHALL pulse one cycle when start arrives while busy.
REQ-014 fail_cnt  output  16  SHALL count total fail pulses, all channels.
REQ-015 pass_cnt  output  16  SHALL count total pass pulses, all channels.

Function
REQ-016 Each channel SHALL be a two-state FSM: IDLE, WAIT; counter width clog2(MAX_DLY+2).
REQ-017 IDLE with start=1 at edge k SHALL go to WAIT, counter=0; busy high from the cycle after edge k.
REQ-018 In WAIT, distance d of edge k+d SHALL equal counter+1; counter increments each edge.
REQ-019 done at edge k (same edge as start) SHALL be ignored.
REQ-020 done at edge k+d, MIN_DLY<=d<=MAX_DLY, SHALL set pass for one cycle and return to IDLE (first_match: first qualifying done ends attempt; later dones ignored).
REQ-021 done at d<MIN_DLY SHALL give fail + IDLE if EARLY_FAIL=1, otherwise SHALL be ignored with WAIT continuing.
REQ-022 No qualifying done by edge k+MAX_DLY SHALL give fail at edge k+MAX_DLY+1 and return to IDLE; counter SHALL never wrap.
REQ-023 dis=1 SHALL have priority over done/timeout: go IDLE, no pass/fail; dis in IDLE SHALL also block start.
REQ-024 start while WAIT (not ending this edge) SHALL be ignored and pulse ovl; attempt continues.
REQ-025 start on the edge an attempt ends with a verdict SHALL open a new attempt (back-to-back, no ovl).
REQ-026 pass, fail, ovl SHALL be registered, mutually exclusive per channel per cycle.
REQ-027 Counters SHALL add popcount of pass/fail pulses each cycle, saturating at 16'hFFFF.

Reset
REQ-028 rst_n low SHALL immediately force all channels IDLE, counters 0, busy/pass/fail/ovl 0, fail_cnt/pass_cnt 0.
REQ-029 Reset mid-attempt SHALL discard the attempt with no verdict; first start after deassertion SHALL behave as from IDLE.

Configuration
REQ-030 Macro SEQ_RANGE_CHECKER_STATS_EN defined SHALL build fail_cnt and pass_cnt per REQ-027.
REQ-031 Macro undefined SHALL remove counter logic; fail_cnt and pass_cnt SHALL be constant 0; other behaviour unchanged.

Verification (defaults, NCH=4)
REQ-032 start[0] edge 1, done[0] edge 4 (d=3) -> pass[0] one cycle after edge 4, busy[0] low after, pass_cnt=1.
REQ-033 start[1] edge 1, no done -> fail[1] after edge 6 (d=5), fail_cnt=1; done[1] at edge 8 -> no response.
REQ-034 start[2] edge 1, done[2] edges 1 and 3 and 4 -> pass[2] after edge 3 only; EARLY_FAIL=0 with MIN_DLY=3, done at d=1 then d=3 -> single pass.
REQ-035 start[3] edge 1, start[3] edge 2 -> ovl[3] after edge 2; dis[3] edge 3 -> busy[3] low, no pass/fail.
REQ-036 All four channels pass same cycle -> pass_cnt +=4; rst_n low mid-attempt -> all outputs 0 asynchronously.
REQ-037 Build without SEQ_RANGE_CHECKER_STATS_EN, rerun REQ-032 -> pass identical, pass_cnt stays 0.
